// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch and indirect-address resolution stage feeding
//            the control unit. Owns PC, IR and the effective address.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                DWIDTH   = 16,
  parameter int                AWIDTH   = 12,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetch,
  input  logic              i_is_ind,
  input  logic              i_branch,
  input  logic [AWIDTH-1:0] i_branch_addr,
  input  logic              i_skip,
  input  logic              i_mem_ack,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic              o_mem_req,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_ir,
  output logic [AWIDTH-1:0] o_pc,
  output logic [AWIDTH-1:0] o_ea,
  output logic              o_decoding,
  output logic              o_ind_done,
  output logic              o_busy
);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_fetch    = 3'd1;
  localparam logic [2:0] c_decode   = 3'd2;
  localparam logic [2:0] c_wait_ex  = 3'd3;
  localparam logic [2:0] c_ind      = 3'd4;
  localparam logic [2:0] c_ind_done = 3'd5;

  localparam logic [AWIDTH-1:0] c_pc_one = {{(AWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [AWIDTH-1:0] ea_q, ea_d;
  logic              ind_used_q, ind_used_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_idle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ea_q       <= '0;
      ind_used_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ea_q       <= ea_d;
      ind_used_q <= ind_used_d;
    end
  end

  // Next-state and datapath update; indirect entry pre-empts branch/skip/fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ea_d       = ea_q;
    ind_used_d = ind_used_q;
    case (state_q)
      c_idle: begin
        if (i_fetch) state_d = c_fetch;
      end
      c_fetch: begin
        if (i_mem_ack) begin
          ir_d       = i_mem_rdata;
          ea_d       = i_mem_rdata[AWIDTH-1:0];
          pc_d       = pc_q + c_pc_one;
          ind_used_d = 1'b0;
          state_d    = c_decode;
        end
      end
      c_decode: begin
        state_d = c_wait_ex;
      end
      c_wait_ex: begin
        if (i_is_ind && ir_q[DWIDTH-1] && !ind_used_q) begin
          state_d = c_ind;
        end else begin
          // Branch wins over skip; a same-cycle fetch sees the updated PC
          if (i_branch)    pc_d = i_branch_addr;
          else if (i_skip) pc_d = pc_q + c_pc_one;
          if (i_fetch)     state_d = c_fetch;
        end
      end
      c_ind: begin
        if (i_mem_ack) begin
          ea_d       = i_mem_rdata[AWIDTH-1:0];
          ind_used_d = 1'b1;
          state_d    = c_ind_done;
        end
      end
      c_ind_done: begin
        state_d = c_wait_ex;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  // Outputs decoded from the state register and the datapath registers only
  always_comb begin
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_decoding = 1'b0;
    o_ind_done = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      c_fetch: begin
        o_mem_req  = 1'b1;
        o_mem_addr = pc_q;
        o_busy     = 1'b1;
      end
      c_decode: begin
        o_decoding = 1'b1;
        o_busy     = 1'b1;
      end
      c_ind: begin
        o_mem_req  = 1'b1;
        o_mem_addr = ea_q;
        o_busy     = 1'b1;
      end
      c_ind_done: begin
        o_ind_done = 1'b1;
        o_busy     = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_ir = ir_q;
  assign o_pc = pc_q;
  assign o_ea = ea_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit: decode and indirect results are
//            queued when stimulus is driven and compared on the output pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] ir;
    logic [11:0] pc;
    logic [11:0] ea;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_fetch = 1'b0, i_is_ind = 1'b0, i_branch = 1'b0, i_skip = 1'b0;
  logic [11:0] i_branch_addr = '0;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  wire         o_mem_req, o_decoding, o_ind_done, o_busy;
  wire  [11:0] o_mem_addr, o_pc, o_ea;
  wire  [15:0] o_ir;
  wire         d2_mem_req, d2_decoding, d2_ind_done, d2_busy;
  wire  [11:0] d2_mem_addr, d2_pc, d2_ea;
  wire  [15:0] d2_ir;

  logic [15:0] mem [0:4095];
  exp_t        dec_q[$];
  logic [11:0] ind_q[$];
  int          total = 0;
  int          bad = 0;
  logic [11:0] m_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'h000)) u_dut (
    .clk(clk), .reset(reset), .i_fetch(i_fetch), .i_is_ind(i_is_ind),
    .i_branch(i_branch), .i_branch_addr(i_branch_addr), .i_skip(i_skip),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_ir(o_ir), .o_pc(o_pc),
    .o_ea(o_ea), .o_decoding(o_decoding), .o_ind_done(o_ind_done), .o_busy(o_busy)
  );

  // Second instance only to observe the wrap from a 0xFFF reset PC
  fetch_unit #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'hFFF)) u_dut_wrap (
    .clk(clk), .reset(reset), .i_fetch(i_fetch), .i_is_ind(i_is_ind),
    .i_branch(i_branch), .i_branch_addr(i_branch_addr), .i_skip(i_skip),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_req(d2_mem_req), .o_mem_addr(d2_mem_addr), .o_ir(d2_ir), .o_pc(d2_pc),
    .o_ea(d2_ea), .o_decoding(d2_decoding), .o_ind_done(d2_ind_done), .o_busy(d2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and service the scoreboards on the output pulses
  task automatic tick();
    exp_t e;
    logic [11:0] ea;
    @(posedge clk);
    #1;
    if (o_decoding && o_ind_done) chk("dec_ind_overlap", 1, 0);
    if (o_decoding) begin
      if (dec_q.size() == 0) chk("unexpected_decode", 1, 0);
      else begin
        e = dec_q.pop_front();
        chk("dec_ir", {16'h0, o_ir}, {16'h0, e.ir});
        chk("dec_pc", {20'h0, o_pc}, {20'h0, e.pc});
        chk("dec_ea", {20'h0, o_ea}, {20'h0, e.ea});
      end
    end
    if (o_ind_done) begin
      if (ind_q.size() == 0) chk("unexpected_ind_done", 1, 0);
      else begin
        ea = ind_q.pop_front();
        chk("ind_ea", {20'h0, o_ea}, {20'h0, ea});
      end
    end
  endtask

  // Queue the expected decode result for a fetch issued at the model PC
  task automatic expect_fetch();
    exp_t e;
    e.ir = mem[m_pc];
    e.pc = m_pc + 12'h001;
    e.ea = mem[m_pc][11:0];
    dec_q.push_back(e);
    m_pc = m_pc + 12'h001;
  endtask

  // Wait for a request, hold off the ack for 'delay' cycles, then answer
  task automatic serve(input int delay, input logic [11:0] exp_addr);
    int n = 0;
    while (!o_mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'h0, o_mem_req}, 32'h1);
    for (int i = 0; i < delay; i++) begin
      chk("addr_hold", {20'h0, o_mem_addr}, {20'h0, exp_addr});
      tick();
      chk("req_hold", {31'h0, o_mem_req}, 32'h1);
    end
    chk("mem_addr", {20'h0, o_mem_addr}, {20'h0, exp_addr});
    i_mem_ack   = 1'b1;
    i_mem_rdata = mem[exp_addr];
    tick();
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    chk("req_drop", {31'h0, o_mem_req}, 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    mem[12'h000] = 16'h2123;
    mem[12'h001] = 16'h9050;
    mem[12'h050] = 16'h0ABC;
    mem[12'h300] = 16'h1234;
    mem[12'hFFF] = 16'h0777;

    // Reset state
    tick();
    tick();
    chk("rst_pc", {20'h0, o_pc}, 32'h0);
    chk("rst_ir", {16'h0, o_ir}, 32'h0);
    chk("rst_ea", {20'h0, o_ea}, 32'h0);
    chk("rst_req", {31'h0, o_mem_req}, 32'h0);
    chk("rst_addr", {20'h0, o_mem_addr}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_pc_wrapinst", {20'h0, d2_pc}, 32'hFFF);
    reset = 1'b0;
    m_pc  = 12'h000;
    tick();

    // Basic fetch, ack on the first request cycle
    i_fetch = 1'b1;
    expect_fetch();
    tick();
    i_fetch = 1'b0;
    chk("fetch_busy", {31'h0, o_busy}, 32'h1);
    serve(0, 12'h000);
    chk("decode_2cyc", {31'h0, o_decoding}, 32'h1);
    chk("wrap_from_fff", {20'h0, d2_pc}, 32'h000);
    tick();
    chk("decode_one_cycle", {31'h0, o_decoding}, 32'h0);

    // Non-indirect IR ignores i_is_ind; then fetch the indirect instruction
    i_is_ind = 1'b1;
    tick();
    i_is_ind = 1'b0;
    chk("ind_ignored_ir15_0", {31'h0, o_mem_req}, 32'h0);
    i_fetch = 1'b1;
    expect_fetch();
    tick();
    i_fetch = 1'b0;
    serve(0, 12'h001);
    tick();

    // Indirect resolution with a two-cycle ack delay
    i_is_ind = 1'b1;
    ind_q.push_back(mem[12'h050][11:0]);
    tick();
    i_is_ind = 1'b0;
    serve(2, 12'h050);
    chk("ind_done_pulse", {31'h0, o_ind_done}, 32'h1);
    tick();
    chk("ind_done_one_cycle", {31'h0, o_ind_done}, 32'h0);
    i_is_ind = 1'b1;
    tick();
    i_is_ind = 1'b0;
    chk("second_ind_no_req", {31'h0, o_mem_req}, 32'h0);
    tick();
    chk("second_ind_no_req2", {31'h0, o_mem_req}, 32'h0);
    chk("ind_pc_kept", {20'h0, o_pc}, 32'h002);

    // Branch, skip and fetch together: branch wins, fetch uses new PC
    i_branch = 1'b1; i_branch_addr = 12'h300; i_skip = 1'b1; i_fetch = 1'b1;
    m_pc = 12'h300;
    expect_fetch();
    tick();
    i_branch = 1'b0; i_skip = 1'b0; i_fetch = 1'b0;
    chk("branch_pc", {20'h0, o_pc}, 32'h300);
    serve(0, 12'h300);
    tick();

    // Skip alone at PC 0x005
    i_branch = 1'b1; i_branch_addr = 12'h005;
    tick();
    i_branch = 1'b0;
    chk("branch_to_5", {20'h0, o_pc}, 32'h005);
    i_skip = 1'b1;
    tick();
    i_skip = 1'b0;
    chk("skip_pc", {20'h0, o_pc}, 32'h006);

    // Wrap at 0xFFF with a five-cycle ack delay
    i_branch = 1'b1; i_branch_addr = 12'hFFF; i_fetch = 1'b1;
    m_pc = 12'hFFF;
    expect_fetch();
    tick();
    i_branch = 1'b0; i_fetch = 1'b0;
    serve(5, 12'hFFF);
    tick();

    // Stray ack in WAIT_EX changes nothing
    i_mem_ack = 1'b1; i_mem_rdata = 16'hFFFF;
    tick();
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    tick();
    chk("stray_ir", {16'h0, o_ir}, 32'h0777);
    chk("stray_ea", {20'h0, o_ea}, 32'h777);
    chk("stray_pc", {20'h0, o_pc}, 32'h000);
    chk("stray_req", {31'h0, o_mem_req}, 32'h0);

    // Reset during FETCH, ack in the cycle right after reset
    i_fetch = 1'b1;
    tick();
    i_fetch = 1'b0;
    chk("pre_reset_req", {31'h0, o_mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_req_drop", {31'h0, o_mem_req}, 32'h0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'hBEEF;
    tick();
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset_ir", {16'h0, o_ir}, 32'h0);
    chk("post_reset_pc", {20'h0, o_pc}, 32'h0);
    chk("post_reset_ea", {20'h0, o_ea}, 32'h0);
    chk("post_reset_busy", {31'h0, o_busy}, 32'h0);
    chk("post_reset_pc_wrapinst", {20'h0, d2_pc}, 32'hFFF);

    chk("dec_queue_empty", dec_q.size(), 0);
    chk("ind_queue_empty", ind_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
